// File: rtl/sbase_seq_pkg.sv
// sbase_seq_pkg: shared FSM state type, phase count and pointer-width helper
// for the four-phase sequencer and its round-robin arbiter.
package sbase_seq_pkg;

    localparam int NPHASE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptrWidth(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/sbase_rr_arb.sv
// sbase_rr_arb: combinational round-robin pick. The search starts one past
// the pointer and wraps at NREQ-1; the first asserted request wins.
module sbase_rr_arb
    import sbase_seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptrWidth(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    logic [PW-1:0] scanIdx;

    // Walk the requesters in rotated order and grant the first one found.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        scanIdx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scanIdx = PW'((int'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[scanIdx]) begin
                gnt_o[scanIdx] = 1'b1;
                valid_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sbase_seq_sched.sv
// sbase_seq_sched: shares a four-phase sequencer between NREQ requesters.
// A granted requester owns the sequencer from phase 0 through the DONE cycle;
// STEP (qualified by RDY_IN) walks the phases. All outputs are registered.
// Optional feature: define SBASE_SEQ_TIMEOUT_EN to abort a run that sits in
// one phase for TIMEOUT cycles (ERR pulse, no DONE, pointer moves past the
// aborted requester). Without it ERR is tied low and runs wait indefinitely.
module sbase_seq_sched
    import sbase_seq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              R_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic              STEP,
    input  logic              RDY_IN,
    output logic [NREQ-1:0]   GNT,
    output logic              RDY,
    output logic [NPHASE-1:0] STATE,
    output logic [NPHASE-1:0] POUT,
    output logic              DONE,
    output logic              ERR
);

    localparam int         PW        = ptrWidth(NREQ);
    localparam logic [1:0] LastPhase = 2'(NPHASE - 1);

    seq_state_e        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              rdy_q, rdy_d;
    logic [NPHASE-1:0] stOut_q, stOut_d;
    logic [NPHASE-1:0] pout_q, pout_d;
    logic              done_q, done_d;

    logic [NREQ-1:0]   arbGnt;
    logic              arbValid;
    logic [PW-1:0]     ownerIdx;
    logic              advance;

`ifdef SBASE_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expired;

    // cnt_q counts cycles already spent in the phase, so the last allowed
    // cycle is the one where it reads TIMEOUT-1.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));
    assign ERR     = err_q;
`else
    localparam int unusedTimeout = TIMEOUT;

    assign ERR = 1'b0;
`endif

    assign advance = STEP && RDY_IN;

    sbase_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (arbGnt),
        .valid_o (arbValid)
    );

    // Index of the current owner, used to park the pointer when the run ends.
    always_comb begin
        ownerIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                ownerIdx = PW'(i);
            end
        end
    end

    // Next-state and next registered-output values for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        rdy_d   = rdy_q;
        stOut_d = stOut_q;
        pout_d  = '0;
        done_d  = 1'b0;
`ifdef SBASE_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                rdy_d   = 1'b1;
                gnt_d   = '0;
                stOut_d = '0;
                phase_d = 2'd0;
                if (RDY_IN && arbValid) begin
                    state_d = ST_RUN;
                    gnt_d   = arbGnt;
                    rdy_d   = 1'b0;
                    stOut_d = NPHASE'(1);
                    pout_d  = NPHASE'(1);
`ifdef SBASE_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (phase_q == LastPhase) begin
                        state_d = ST_DONE;
                        stOut_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        stOut_d = NPHASE'(1) << phase_d;
                        pout_d  = NPHASE'(1) << phase_d;
                    end
`ifdef SBASE_SEQ_TIMEOUT_EN
                    cnt_d = '0;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    phase_d = 2'd0;
                    gnt_d   = '0;
                    stOut_d = '0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    ptr_d   = ownerIdx;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
                gnt_d   = '0;
                rdy_d   = 1'b1;
                ptr_d   = ownerIdx;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
                gnt_d   = '0;
                stOut_d = '0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; a low R_N returns everything to idle.
    always_ff @(posedge CLK) begin
        if (!R_N) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            gnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            rdy_q   <= 1'b1;
            stOut_q <= '0;
            pout_q  <= '0;
            done_q  <= 1'b0;
`ifdef SBASE_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            rdy_q   <= rdy_d;
            stOut_q <= stOut_d;
            pout_q  <= pout_d;
            done_q  <= done_d;
`ifdef SBASE_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign GNT   = gnt_q;
    assign RDY   = rdy_q;
    assign STATE = stOut_q;
    assign POUT  = pout_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_sbase_seq_sched.sv
// tb_sbase_seq_sched: self-checking bench for sbase_seq_sched. A directed
// vector table, hand-written multi-cycle sequences and a random run checked
// against a phase-level reference model.
module tb_sbase_seq_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic            CLK = 1'b0;
    logic            R_N;
    logic [NREQ-1:0] REQ;
    logic            STEP;
    logic            RDY_IN;
    logic [NREQ-1:0] GNT;
    logic            RDY;
    logic [3:0]      STATE;
    logic [3:0]      POUT;
    logic            DONE;
    logic            ERR;

    int checks = 0;
    int errors = 0;

    // Reference model: mPhase -1 idle, 0..3 running phase, 4 done cycle.
    int mPhase    = -1;
    int mOwner    = -1;
    int mLast     = NREQ - 1;
    int mCnt      = 0;
    bit mNewPhase = 1'b0;
    bit mErr      = 1'b0;

    typedef struct {
        bit         rn;
        logic [3:0] req;
        bit         step;
        bit         rdyIn;
        logic [3:0] gnt;
        logic [3:0] st;
        logic [3:0] pout;
        bit         rdy;
        bit         done;
    } vec_t;

    vec_t       vecs[15];
    logic [3:0] expG;

    sbase_seq_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .CLK    (CLK),
        .R_N    (R_N),
        .REQ    (REQ),
        .STEP   (STEP),
        .RDY_IN (RDY_IN),
        .GNT    (GNT),
        .RDY    (RDY),
        .STATE  (STATE),
        .POUT   (POUT),
        .DONE   (DONE),
        .ERR    (ERR)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelStep(input bit rn, input logic [3:0] req, input bit step, input bit rdyIn);
        int cand;
        mNewPhase = 1'b0;
        mErr      = 1'b0;
        if (!rn) begin
            mPhase = -1;
            mOwner = -1;
            mLast  = NREQ - 1;
            mCnt   = 0;
        end else if (mPhase == -1) begin
            if (rdyIn && req != 4'h0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    cand = (mLast + k) % NREQ;
                    if (mOwner < 0 && req[cand]) mOwner = cand;
                end
                mPhase    = 0;
                mNewPhase = 1'b1;
                mCnt      = 1;
            end
        end else if (mPhase == 4) begin
            mLast  = mOwner;
            mOwner = -1;
            mPhase = -1;
        end else if (step && rdyIn) begin
            mPhase    = mPhase + 1;
            mNewPhase = (mPhase < 4);
            mCnt      = 1;
        end
`ifdef SBASE_SEQ_TIMEOUT_EN
        else if (mCnt == TMO) begin
            mLast  = mOwner;
            mOwner = -1;
            mPhase = -1;
            mErr   = 1'b1;
        end else begin
            mCnt = mCnt + 1;
        end
`endif
    endtask

    // Drive one cycle of inputs, update the model, and settle after the edge.
    task automatic applyStimulus(input bit rn, input logic [3:0] req, input bit step, input bit rdyIn);
        R_N    = rn;
        REQ    = req;
        STEP   = step;
        RDY_IN = rdyIn;
        modelStep(rn, req, step, rdyIn);
        @(posedge CLK);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every output with the values the model predicts.
    task automatic checkOutput(input string tag);
        logic [3:0] eGnt, eSt, ePout;
        eGnt  = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'h0;
        eSt   = (mPhase >= 0 && mPhase < 4) ? (4'b0001 << mPhase) : 4'h0;
        ePout = mNewPhase ? eSt : 4'h0;
        checkVal({tag, ".GNT"},   32'(GNT),   32'(eGnt));
        checkVal({tag, ".STATE"}, 32'(STATE), 32'(eSt));
        checkVal({tag, ".POUT"},  32'(POUT),  32'(ePout));
        checkVal({tag, ".RDY"},   32'(RDY),   32'(mPhase == -1));
        checkVal({tag, ".DONE"},  32'(DONE),  32'(mPhase == 4));
        checkVal({tag, ".ERR"},   32'(ERR),   32'(mErr));
    endtask

    initial begin
        R_N = 1'b0; REQ = '0; STEP = 1'b0; RDY_IN = 1'b0;

        //             rn    req   stp   rdyI  gnt   st    pout  rdy   done
        vecs[0]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 4'h2, 4'h2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 4'h4, 4'h4, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 4'h8, 4'h8, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'h2, 1'b0, 1'b1, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'h1, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 4'h0, 1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h2, 4'h2, 4'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h2, 4'h2, 4'h0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rn, vecs[i].req, vecs[i].step, vecs[i].rdyIn);
            checkVal($sformatf("vec%0d.GNT", i),   32'(GNT),   32'(vecs[i].gnt));
            checkVal($sformatf("vec%0d.STATE", i), 32'(STATE), 32'(vecs[i].st));
            checkVal($sformatf("vec%0d.POUT", i),  32'(POUT),  32'(vecs[i].pout));
            checkVal($sformatf("vec%0d.RDY", i),   32'(RDY),   32'(vecs[i].rdy));
            checkVal($sformatf("vec%0d.DONE", i),  32'(DONE),  32'(vecs[i].done));
            checkVal($sformatf("vec%0d.ERR", i),   32'(ERR),   32'd0);
        end

        $display("[TB] round-robin over five back-to-back runs");
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            expG = 4'b0001 << (r % 4);
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
            checkVal($sformatf("rr%0d.GNT", r), 32'(GNT), 32'(expG));
            for (int s = 0; s < 4; s++) applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
            checkVal($sformatf("rr%0d.DONE", r),    32'(DONE), 32'd1);
            checkVal($sformatf("rr%0d.GNTheld", r), 32'(GNT),  32'(expG));
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
            checkVal($sformatf("rr%0d.RDY", r),     32'(RDY),  32'd1);
            checkVal($sformatf("rr%0d.GNTclr", r),  32'(GNT),  32'd0);
        end

        $display("[TB] reset during phase 2");
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
        checkVal("midrst.STATEph2", 32'(STATE), 32'h4);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b1);
        checkVal("midrst.GNT",   32'(GNT),   32'd0);
        checkVal("midrst.STATE", 32'(STATE), 32'd0);
        checkVal("midrst.RDY",   32'(RDY),   32'd1);
        checkVal("midrst.DONE",  32'(DONE),  32'd0);
        checkVal("midrst.ERR",   32'(ERR),   32'd0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
        checkVal("midrst.nextGNT", 32'(GNT), 32'h1);

`ifdef SBASE_SEQ_TIMEOUT_EN
        $display("[TB] timeout abort in phase 0");
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b1);
        for (int c = 2; c <= TMO; c++) begin
            applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
            checkVal($sformatf("tmo.ERRlow%0d", c), 32'(ERR), 32'd0);
        end
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
        checkVal("tmo.ERR",  32'(ERR),  32'd1);
        checkVal("tmo.DONE", 32'(DONE), 32'd0);
        checkVal("tmo.GNT",  32'(GNT),  32'd0);
        checkVal("tmo.RDY",  32'(RDY),  32'd1);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
        checkVal("tmo.nextGNT", 32'(GNT), 32'h2);
`endif

        $display("[TB] random traffic against the reference model");
        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 79) != 0),
                          ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) != 0));
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
